// File: rtl/instruction_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instruction_fetch_ctrl
//
// Sequential fetch from the single-cycle program ROM into a small prefetch
// FIFO that feeds decode through a valid/ready handshake. Owns the fetch PC,
// flushes and restarts on redirect, and traps misaligned (and optionally
// out-of-range) fetch addresses.
//
// Build option:
//   FETCH_BOUNDS_CHECK_EN  defined   -> fetches outside
//                                       [RESET_PC, RESET_PC + 4*MEMORY_DEPTH)
//                                       fault
//                          undefined -> only the alignment check applies and
//                                       fetch_pc wraps freely
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   fetch_en_i     run request; 0 stops new fetches
//   redirect_i     one-cycle pulse: flush FIFO, restart at redirect_pc_i
//   redirect_pc_i  redirect target byte address
//   mem_addr_o     ROM byte address (registered fetch PC)
//   mem_instr_i    combinational ROM data for mem_addr_o
//   instr_valid_o  FIFO head valid
//   instr_ready_i  decode accepts the head this cycle
//   instr_o        head instruction (0 when empty)
//   pc_o           head PC (0 when empty)
//   fault_o        fetch fault latched
//   fault_addr_o   address that faulted
// -----------------------------------------------------------------------------
module instruction_fetch_ctrl #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
   parameter int                    FIFO_DEPTH   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_en_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_instr_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  fault_o,
   output logic [DATA_WIDTH-1:0] fault_addr_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [DATA_WIDTH-1:0] TEXT_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);
`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [AW-1:0]         rd_ptr, wr_ptr;
   logic [AW:0]           count;
   logic [DATA_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
   logic                  pop, push, pc_legal, fault_now;

   // Offset form of the range check avoids overflow of RESET_PC + TEXT_BYTES.
   function automatic logic addr_legal(input logic [DATA_WIDTH-1:0] a);
      logic aligned, in_range;
      aligned  = (a[1:0] == 2'b00);
      in_range = (a >= RESET_PC) && ((a - RESET_PC) < TEXT_BYTES);
      return aligned && (!BOUNDS_EN || in_range);
   endfunction

   assign instr_valid_o = (count != '0);
   assign pop           = instr_valid_o && instr_ready_i;
   assign pc_legal      = addr_legal(fetch_pc);
   assign push          = !redirect_i && (state == RUN) && fetch_en_i && pc_legal &&
                          ((count != FULL_C) || pop);
   assign fault_now     = !redirect_i && (state == RUN) && fetch_en_i && !pc_legal;

   assign mem_addr_o = fetch_pc;
   assign instr_o    = instr_valid_o ? fifo_instr[rd_ptr] : '0;
   assign pc_o       = instr_valid_o ? fifo_pc[rd_ptr]    : '0;

   // Next-state logic; redirect overrides everything.
   always_comb begin
      state_nxt = state;
      if (redirect_i) begin
         state_nxt = fetch_en_i ? RUN : HALT;
      end else begin
         unique case (state)
            IDLE:    if (fetch_en_i) state_nxt = RUN;
            RUN:     if (!fetch_en_i) state_nxt = HALT;
                     else if (!pc_legal) state_nxt = FAULT;
            HALT:    if (fetch_en_i) state_nxt = RUN;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Control registers: state, fetch PC, FIFO pointers, fault capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         fetch_pc     <= RESET_PC;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         fault_o      <= 1'b0;
         fault_addr_o <= '0;
      end else begin
         state <= state_nxt;
         if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fault_o  <= 1'b0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + DATA_WIDTH'(4);
               wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
               2'b10:   count <= count + (AW+1)'(1);
               2'b01:   count <= count - (AW+1)'(1);
               default: count <= count;
            endcase
            if (fault_now) begin
               fault_o      <= 1'b1;
               fault_addr_o <= fetch_pc;
            end
         end
      end
   end

   // FIFO storage: data only, validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= fetch_pc;
         fifo_instr[wr_ptr] <= mem_instr_i;
      end
   end

endmodule
